run_monitor: RTL and testbench
==============================

// Module: run_monitor
// PURPOSE
//   Synthesizable run controller for the pipelined mips core; replaces free-running sim-only clk/reset stimulus.
//   Sequences core reset, counts cycles and retired instructions, stops the run on halt PC, self-loop or timeout.
//   Sits between the top-level clk/reset and the core's reset pin; observes the core's commit (WB) stream.
// PARAMETERS
//   ADDR_W        32     width of commit_pc / halt_pc / last_pc
//   CNT_W         32     width of cycle_count / retire_count; both saturate at all-ones
//   RESET_CYCLES  4      cycles core_reset is held high before RUN; legal range >=1
//   MAX_CYCLES    10000  RUN-cycle budget before TIMEOUT; legal range >=1 and <2^CNT_W
//   LOOP_LIMIT    8      consecutive same-PC commits that count as a halt; 0 disables loop detection
// PORTS
//   clk           in   1       clock, all state on rising edge
//   reset         in   1       asynchronous, active-low reset
//   start         in   1       run request pulse; sampled every cycle
//   halt_en       in   1       enables halt_pc match
//   halt_pc       in   ADDR_W  PC whose commit ends the run
//   commit_valid  in   1       one instruction retires this cycle
//   commit_pc     in   ADDR_W  PC of the retiring instruction
//   core_reset    out  1       active-high synchronous reset to mips core
//   running       out  1       state == RUN
//   done          out  1       state is HALTED or TIMEOUT
//   halted        out  1       run ended by halt_pc or loop detection
//   timeout       out  1       run ended by cycle budget
//   cycle_count   out  CNT_W   RUN cycles elapsed in current run
//   retire_count  out  CNT_W   commits accepted in current run
//   last_pc       out  ADDR_W  PC of most recent accepted commit
// BEHAVIOUR
//   Reset (reset==0, async): state=IDLE; core_reset=1; running/done/halted/timeout=0;
//     cycle_count/retire_count/last_pc/hold_cnt/rep_cnt=0. All outputs registered or decoded from state only.
//   States: IDLE, HOLD, RUN, HALTED, TIMEOUT. core_reset=1 in every state except RUN.
//   IDLE: start=1 -> HOLD, clear hold_cnt.
//   HOLD: hold_cnt++ each cycle; at hold_cnt==RESET_CYCLES-1 -> RUN (core_reset high exactly RESET_CYCLES cycles).
//   Entering HOLD (from any state) clears cycle_count, retire_count, last_pc, rep_cnt, halted, timeout.
//   RUN: every cycle cycle_count++ (saturating). Commits are accepted only in RUN.
//     Accepted commit: retire_count++ (saturating); last_pc<=commit_pc;
//       rep_cnt <= (commit_pc==last_pc && retire_count!=0) ? rep_cnt+1 : 0.
//     Halt event this cycle: commit_valid && ((halt_en && commit_pc==halt_pc) ||
//       (LOOP_LIMIT!=0 && next rep_cnt==LOOP_LIMIT)). Halting commit is counted.
//     Halt event -> HALTED, halted<=1. Else if cycle_count==MAX_CYCLES-1 -> TIMEOUT, timeout<=1
//       (final cycle_count==MAX_CYCLES). Halt and timeout in same cycle: halt wins.
//   HALTED/TIMEOUT: counters, last_pc, flags frozen; commit inputs ignored; start=1 -> HOLD (new run).
//   start in HOLD or RUN is ignored; start held high re-runs only after done.
//   commit_valid outside RUN is ignored (core is in reset).
//   Saturation: counters stick at {CNT_W{1'b1}}, never wrap.
//   reset low mid-run: immediate return to IDLE, core_reset=1 asynchronously, all counts lost.
// TESTING
//   Defaults, reset low 3 cycles then high, start pulse -> core_reset high exactly 4 cycles, then running=1, cycle_count=0.
//   RUN, halt_en=1 halt_pc=0x3010, commits 0x3000,0x3004,0x3008,0x300c,0x3010 -> HALTED next cycle, retire_count=5, last_pc=0x3010.
//   LOOP_LIMIT=3, commits 0x3000,0x3004,0x3004,0x3004,0x3004 -> halted=1 after 5th commit, retire_count=5.
//   MAX_CYCLES=20, no halt -> timeout=1 after 20 RUN cycles, cycle_count=20; halt at cycle 20 instead -> halted=1, timeout=0.
//   start pulse in HALTED -> HOLD, counters 0, flags clear; start pulses in HOLD/RUN -> no effect.
//   reset low during RUN at cycle 7 -> same-cycle core_reset=1, state IDLE, all counts 0; commits then ignored.

Source files
------------

// File: rtl/run_monitor.sv
// Run controller for the pipelined mips core: sequences core reset, counts RUN cycles/commits, ends on halt PC, self-loop or budget.
// Decisions take effect on the next clk edge; the commit stream has no backpressure and is only observed while running.
module run_monitor #(
  parameter int ADDR_W       = 32,
  parameter int CNT_W        = 32,
  parameter int RESET_CYCLES = 4,
  parameter int MAX_CYCLES   = 10000,
  parameter int LOOP_LIMIT   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt_en,
  input  logic [ADDR_W-1:0] halt_pc,
  input  logic              commit_valid,
  input  logic [ADDR_W-1:0] commit_pc,
  output logic              core_reset,
  output logic              running,
  output logic              done,
  output logic              halted,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  retire_count,
  output logic [ADDR_W-1:0] last_pc
);

  typedef enum logic [2:0] {IDLE, HOLD, RUN, HALTED, TIMEOUT} state_t;

  localparam int                HOLD_W    = $clog2(RESET_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CYC_LAST  = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LOOP_CMP  = CNT_W'(LOOP_LIMIT);

  state_t             state;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [CNT_W-1:0]   rep_cnt;
  logic [CNT_W-1:0]   rep_nxt;
  logic               pc_hit;
  logic               loop_hit;
  logic               halt_evt;
  logic               enter_hold;

  // rep_cnt counts repeats of the previous PC; the very first commit of a run never counts as a repeat.
  always_comb begin
    rep_nxt = '0;
    if ((commit_pc == last_pc) && (retire_count != '0)) begin
      rep_nxt = (rep_cnt == CNT_MAX) ? rep_cnt : rep_cnt + CNT_W'(1);
    end
    pc_hit     = halt_en && (commit_pc == halt_pc);
    loop_hit   = (LOOP_LIMIT != 0) && (rep_nxt == LOOP_CMP);
    halt_evt   = commit_valid && (pc_hit || loop_hit);
    enter_hold = start && ((state == IDLE) || (state == HALTED) || (state == TIMEOUT));
  end

  assign core_reset = (state != RUN);
  assign running    = (state == RUN);
  assign done       = (state == HALTED) || (state == TIMEOUT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      rep_cnt      <= '0;
      cycle_count  <= '0;
      retire_count <= '0;
      last_pc      <= '0;
      halted       <= 1'b0;
      timeout      <= 1'b0;
    end else if (enter_hold) begin
      state        <= HOLD;
      hold_cnt     <= '0;
      rep_cnt      <= '0;
      cycle_count  <= '0;
      retire_count <= '0;
      last_pc      <= '0;
      halted       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state <= RUN;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        RUN: begin
          if (cycle_count != CNT_MAX) begin
            cycle_count <= cycle_count + CNT_W'(1);
          end
          if (commit_valid) begin
            if (retire_count != CNT_MAX) begin
              retire_count <= retire_count + CNT_W'(1);
            end
            last_pc <= commit_pc;
            rep_cnt <= rep_nxt;
          end
          // A halting commit in the final budget cycle still reports as a halt.
          if (halt_evt) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else if (cycle_count == CYC_LAST) begin
            state   <= TIMEOUT;
            timeout <= 1'b1;
          end
        end
        IDLE, HALTED, TIMEOUT: state <= state;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_run_monitor.sv
// Bench for run_monitor: directed vector table, multi-cycle corner sequences, then random traffic against a reference model.
module tb_run_monitor;

  localparam int RC = 4;
  localparam int MX = 20;
  localparam int LL = 3;

  logic        clk = 1'b0;
  logic        reset, start, halt_en, commit_valid;
  logic [31:0] halt_pc, commit_pc;
  logic        core_reset, running, done, halted, timeout;
  logic [31:0] cycle_count, retire_count, last_pc;

  int n_cmp = 0;
  int n_bad = 0;

  run_monitor #(
    .ADDR_W(32), .CNT_W(32), .RESET_CYCLES(RC), .MAX_CYCLES(MX), .LOOP_LIMIT(LL)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .halt_en(halt_en), .halt_pc(halt_pc),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .core_reset(core_reset),
    .running(running), .done(done), .halted(halted), .timeout(timeout),
    .cycle_count(cycle_count), .retire_count(retire_count), .last_pc(last_pc)
  );

  always #5 clk = ~clk;

  // Reference model: a run is "active" from start until it ends; hold_left counts reset cycles still owed.
  bit          m_act, m_hal, m_to;
  int          m_hold;
  longint      m_cyc, m_ret;
  logic [31:0] m_last;
  int          m_hist[$];

  function automatic void model_reset();
    m_act = 0; m_hal = 0; m_to = 0; m_hold = 0;
    m_cyc = 0; m_ret = 0; m_last = '0;
    m_hist.delete();
  endfunction

  function automatic void model_step(input int st, input int he, input int hp, input int cv, input int pc);
    bit hit;
    int tr;
    if (reset !== 1'b1) return;
    hit = 0;
    tr  = 0;
    if (m_act && m_hold > 0) begin
      m_hold--;
    end else if (m_act) begin
      m_cyc++;
      if (cv != 0) begin
        m_hist.push_back(pc);
        m_ret++;
        m_last = pc;
        for (int k = m_hist.size() - 1; k >= 0 && m_hist[k] == pc; k--) tr++;
        hit = ((he != 0) && pc == hp) || (LL != 0 && tr - 1 == LL);
      end
      if (hit) begin
        m_act = 0; m_hal = 1;
      end else if (m_cyc == MX) begin
        m_act = 0; m_to = 1;
      end
    end else if (st != 0) begin
      m_act = 1; m_hold = RC; m_hal = 0; m_to = 0;
      m_cyc = 0; m_ret = 0; m_last = '0;
      m_hist.delete();
    end
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_model(input string nm);
    bit er;
    er = m_act && (m_hold == 0);
    chk({nm, "_flags"}, {core_reset, running, done, halted, timeout},
        {59'd0, !er, er, m_hal || m_to, m_hal, m_to});
    chk({nm, "_cycle_count"}, cycle_count, m_cyc);
    chk({nm, "_retire_count"}, retire_count, m_ret);
    chk({nm, "_last_pc"}, last_pc, m_last);
  endtask

  task automatic cyc(input int st, input int he, input int hp, input int cv, input int pc);
    start        = (st != 0);
    halt_en      = (he != 0);
    halt_pc      = hp;
    commit_valid = (cv != 0);
    commit_pc    = pc;
    model_step(st, he, hp, cv, pc);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  // Start a run and measure how many sampled cycles core_reset stays high before RUN.
  task automatic go_run(input string nm);
    int n;
    cyc(1, 0, 0, 0, 0);
    chk({nm, "_cleared"}, {halted, timeout, cycle_count, retire_count}, 64'd0);
    n = 0;
    while (running !== 1'b1 && n < 50) begin
      n++;
      cyc(0, 0, 0, 0, 0);
    end
    chk({nm, "_hold_len"}, n, RC);
    chk({nm, "_run_cycle0"}, cycle_count, 0);
  endtask

  typedef struct {
    int st, he, hp, cv, pc;
    int e_run, e_done, e_hal, e_cyc, e_ret, e_last;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int          pcs[4];
    int          pc, hp;
    logic [31:0] cur;

    tbl[0]  = '{1, 1, 'h3010, 0, 0,       0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 'h3010, 1, 'h3010,  0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 1, 'h3010, 0, 0,       0, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 'h3010, 0, 0,       0, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 1, 'h3010, 0, 0,       1, 0, 0, 0, 0, 0};
    tbl[5]  = '{0, 1, 'h3010, 1, 'h3000,  1, 0, 0, 1, 1, 'h3000};
    tbl[6]  = '{0, 1, 'h3010, 1, 'h3004,  1, 0, 0, 2, 2, 'h3004};
    tbl[7]  = '{1, 1, 'h3010, 0, 0,       1, 0, 0, 3, 2, 'h3004};
    tbl[8]  = '{0, 1, 'h3010, 1, 'h3008,  1, 0, 0, 4, 3, 'h3008};
    tbl[9]  = '{0, 1, 'h3010, 1, 'h300c,  1, 0, 0, 5, 4, 'h300c};
    tbl[10] = '{0, 1, 'h3010, 1, 'h3010,  0, 1, 1, 6, 5, 'h3010};
    tbl[11] = '{0, 1, 'h3010, 1, 'h4000,  0, 1, 1, 6, 5, 'h3010};
    tbl[12] = '{1, 0, 0,      0, 0,       0, 0, 0, 0, 0, 0};

    reset = 1'b0; start = 1'b0; halt_en = 1'b0; halt_pc = '0;
    commit_valid = 1'b0; commit_pc = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flags", {core_reset, running, done, halted, timeout}, 64'b10000);
    chk("rst_counts", {cycle_count, retire_count}, 64'd0);
    chk("rst_last_pc", last_pc, 0);
    reset = 1'b1;
    idle_cycles(2);
    chk("idle_core_reset", core_reset, 1);

    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].st, tbl[i].he, tbl[i].hp, tbl[i].cv, tbl[i].pc);
      chk($sformatf("vec%0d_running", i), {core_reset, running}, {62'd0, tbl[i].e_run == 0, tbl[i].e_run != 0});
      chk($sformatf("vec%0d_done", i), {done, halted, timeout}, {61'd0, tbl[i].e_done != 0, tbl[i].e_hal != 0, 1'b0});
      chk($sformatf("vec%0d_cycle_count", i), cycle_count, tbl[i].e_cyc);
      chk($sformatf("vec%0d_retire_count", i), retire_count, tbl[i].e_ret);
      chk($sformatf("vec%0d_last_pc", i), last_pc, tbl[i].e_last);
    end

    reset = 1'b0;
    #1;
    reset = 1'b1;
    idle_cycles(1);
    go_run("deflt");

    // Self-loop: the fifth commit is the third repeat of 0x3004.
    cyc(0, 0, 0, 1, 'h3000);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 'h3004);
      chk($sformatf("loop%0d_not_halted", i), {halted, running}, 64'b01);
    end
    cyc(0, 0, 0, 1, 'h3004);
    chk("loop_halted", {halted, timeout, done, running}, 64'b1010);
    chk("loop_retire_count", retire_count, 5);

    go_run("tmo");
    idle_cycles(MX - 1);
    chk("tmo_before", {running, timeout}, 64'b10);
    chk("tmo_before_cycles", cycle_count, MX - 1);
    cyc(0, 0, 0, 0, 0);
    chk("tmo_flags", {timeout, halted, done, running}, 64'b1010);
    chk("tmo_cycles", cycle_count, MX);
    cyc(0, 1, 'h7000, 1, 'h7000);
    chk("tmo_frozen", {cycle_count, retire_count}, {32'(MX), 32'd0});

    go_run("edge");
    idle_cycles(MX - 1);
    cyc(0, 1, 'h5000, 1, 'h5000);
    chk("edge_flags", {halted, timeout, done}, 64'b101);
    chk("edge_counts", {cycle_count, retire_count}, {32'(MX), 32'd1});

    go_run("mid");
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 1, 'h6000 + 4 * i);
    chk("mid_pre_cycles", cycle_count, 7);
    reset = 1'b0;
    #1;
    model_reset();
    chk("mid_async_flags", {core_reset, running, done, halted, timeout}, 64'b10000);
    chk("mid_async_counts", {cycle_count, retire_count, last_pc}, 96'd0);
    cyc(0, 0, 0, 1, 'h6100);
    cyc(1, 0, 0, 1, 'h6104);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) cyc(0, 1, 'h6108, 1, 'h6108);
    chk("mid_after_flags", {core_reset, running, done}, 64'b100);
    chk("mid_after_retire", retire_count, 0);
    check_model("mid_model");

    pcs = '{'h100, 'h104, 'h108, 'h10c};
    cur = 32'h100;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b0;
        #1;
        model_reset();
        check_model("rnd_rst");
        cyc(0, 0, 0, 0, 0);
        reset = 1'b1;
      end
      pc = ($urandom_range(0, 1) == 0) ? int'(cur) : pcs[$urandom_range(0, 3)];
      cur = pc;
      hp = pcs[$urandom_range(0, 3)];
      cyc(($urandom_range(0, 24) == 0) ? 1 : 0, ($urandom_range(0, 7) == 0) ? 1 : 0, hp,
          $urandom_range(0, 1), pc);
      check_model("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
